// File: rtl/key_sched_pkg.sv
// Shared types and helpers for the front-panel key scheduler: key FSM states,
// event kind encodings and the common counter width.
package key_sched_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } key_state_e;

  localparam logic EVT_PRESS  = 1'b0;
  localparam logic EVT_REPEAT = 1'b1;

  // One counter width covers debounce, hold and repeat intervals.
  function automatic int cnt_width(input int deb, input int hold, input int rep);
    int m;
    m = deb;
    if (hold > m) m = hold;
    if (rep > m) m = rep;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_scheduler_if.sv
// Event channel from the key scheduler to its single consumer.
// Handshake: an event transfers on a clock edge where evt_valid && evt_ready;
// while evt_valid is high and evt_ready low, evt_id/evt_kind/evt_valid hold.
interface key_scheduler_if #(
  parameter int N_KEYS = 4
);
  localparam int ID_W = $clog2(N_KEYS);

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_kind;

  modport master (output evt_valid, output evt_id, output evt_kind, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_kind, output evt_ready);
endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, debounce/hold/repeat FSM and its counter.
// Emits a one-cycle post strobe with the event kind, plus the debounced level.
module key_debounce
  import key_sched_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int HOLD_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  output logic       post,
  output logic       post_kind,
  output logic       level,
  output key_state_e state
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             from_rep_q, from_rep_d;
  logic             key_s;

  assign key_s = sync_q[1];
  assign state = state_q;
  assign level = (state_q == PRESSED) || (state_q == REPEAT) || (state_q == DEB_RELEASE);

  always_comb begin
    sync_d     = {sync_q[0], key_raw};
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_rep_d = from_rep_q;
    post       = 1'b0;
    post_kind  = EVT_PRESS;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // In both debounce states the sample that caused entry is the first
    // stable one, so the exit test looks at the incremented count.
    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          post    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d    = DEB_RELEASE;
          cnt_d      = '0;
          from_rep_d = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = REPEAT;
          cnt_d     = '0;
          post      = 1'b1;
          post_kind = EVT_REPEAT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPEAT: begin
        if (!key_s) begin
          state_d    = DEB_RELEASE;
          cnt_d      = '0;
          from_rep_d = 1'b1;
        end else if (cnt_q == REP_LAST) begin
          cnt_d     = '0;
          post      = 1'b1;
          post_kind = EVT_REPEAT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DEB_RELEASE: begin
        if (key_s) begin
          state_d = from_rep_q ? REPEAT : PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      from_rep_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_rep_q <= from_rep_d;
    end
  end

endmodule

// File: rtl/key_scheduler.sv
// Front-panel key scheduler: per-key debounce/repeat, pending-event latches,
// round-robin arbitration and a single registered valid/ready event output.
module key_scheduler
  import key_sched_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [N_KEYS-1:0]     key_raw,
  key_scheduler_if.master       evt,
  output logic                  evt_lost,
  output logic [N_KEYS-1:0]     key_level,
  output logic [3*N_KEYS-1:0]   dbg_key_state
);

  localparam int ID_W  = $clog2(N_KEYS);
  localparam int IDX_W = ID_W + 1;
  localparam int CNT_W = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

  logic [N_KEYS-1:0] post, post_kind;
  key_state_e        key_st [N_KEYS];

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES   (DEB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_deb (
      .clk      (sys_clk),
      .rst      (reset),
      .key_raw  (key_raw[k]),
      .post     (post[k]),
      .post_kind(post_kind[k]),
      .level    (key_level[k]),
      .state    (key_st[k])
    );
    assign dbg_key_state[3*k +: 3] = key_st[k];
  end

  logic [N_KEYS-1:0] pend_q, pend_d, pkind_q, pkind_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d, evt_id_q, evt_id_d, gnt;
  logic              evt_valid_q, evt_valid_d, evt_kind_q, evt_kind_d;
  logic              evt_lost_q, evt_lost_d, found, load;
  logic [IDX_W-1:0]  idx;

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_id    = evt_id_q;
  assign evt.evt_kind  = evt_kind_q;
  assign evt_lost      = evt_lost_q;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 1; i <= N_KEYS; i++) begin
      idx = {1'b0, last_grant_q} + IDX_W'(i);
      if (idx >= IDX_W'(N_KEYS)) idx = idx - IDX_W'(N_KEYS);
      if (!found && pend_q[idx[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = idx[ID_W-1:0];
      end
    end

    pend_d       = pend_q;
    pkind_d      = pkind_q;
    last_grant_d = last_grant_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    evt_kind_d   = evt_kind_q;
    evt_lost_d   = 1'b0;
    load         = !evt_valid_q || evt.evt_ready;

    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_id_d     = gnt;
        evt_kind_d   = pkind_q[gnt];
        pend_d[gnt]  = 1'b0;
        last_grant_d = gnt;
      end
    end

    // Posts see pend after this cycle's grant, so a same-cycle grant frees the slot.
    for (int k = 0; k < N_KEYS; k++) begin
      if (post[k]) begin
        if (pend_d[k]) begin
          evt_lost_d = 1'b1;
        end else begin
          pend_d[k]  = 1'b1;
          pkind_d[k] = post_kind[k];
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pend_q       <= '0;
      pkind_q      <= '0;
      last_grant_q <= ID_W'(N_KEYS - 1);
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_kind_q   <= 1'b0;
      evt_lost_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pkind_q      <= pkind_d;
      last_grant_q <= last_grant_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_kind_q   <= evt_kind_d;
      evt_lost_q   <= evt_lost_d;
    end
  end

endmodule
